// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the UART receive controller.
// Default widths, legal prescales, frame bit counts and FSM states.
package uart_rx_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int SCALER_WIDTH_DEF = 5;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  localparam int START_BITS = 1;
  localparam int STOP_BITS  = 1;

  // Frame timeout counter width
  localparam int TMO_W = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO; push is ignored when full unless popping.
// Ports: push/wdata in, pop in, rdata head, full, empty, count.
module uart_rx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencer: config shadowing, frame timeout, output FIFO, stats.
// Ports: cfg_* config, RX_IN monitor, Prescale/PAR_* out, P_DATA/data_valid in, m_* stream, stats.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int scaler_width = SCALER_WIDTH_DEF,
  parameter int FIFO_DEPTH   = 4,
  parameter int PRESCALE_RST = 8,
  parameter bit PAR_EN_RST   = 1'b1,
  parameter bit PAR_TYP_RST  = 1'b0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        cfg_wr,
  input  logic [scaler_width-1:0]     cfg_prescale,
  input  logic                        cfg_par_en,
  input  logic                        cfg_par_typ,
  output logic                        cfg_pending,
  output logic                        cfg_err,
  input  logic                        RX_IN,
  output logic [scaler_width-1:0]     Prescale,
  output logic                        PAR_EN,
  output logic                        PAR_TYP,
  input  logic [DATA_WIDTH-1:0]       P_DATA,
  input  logic                        data_valid,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  err_cnt,
  output logic [7:0]                  ovf_cnt,
  input  logic                        clr_stats
);

  localparam logic [scaler_width-1:0] P8  = scaler_width'(PRESC_8);
  localparam logic [scaler_width-1:0] P16 = scaler_width'(PRESC_16);
  localparam logic [scaler_width-1:0] P32 = scaler_width'(PRESC_32);
  // A prescale of 32 wraps to 0 in a 5-bit field; 0 means full range.
  localparam int PRESC_FULL = 1 << scaler_width;

  state_t                  state_q, state_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    rx_q;
  logic                    fall;
  logic                    apply;
  logic                    err_inc;
  logic                    presc_legal;
  logic [scaler_width-1:0] sh_prescale;
  logic                    sh_par_en;
  logic                    sh_par_typ;
  logic [TMO_W-1:0]        frame_bits;
  logic [TMO_W-1:0]        presc_eff;
  logic [TMO_W-1:0]        tmo_load;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    ovf_inc;

  assign fall        = rx_q & ~RX_IN;
  assign presc_legal = (cfg_prescale == P8) |
                       (cfg_prescale == P16) |
                       (cfg_prescale == P32);

  assign frame_bits = TMO_W'(START_BITS + DATA_WIDTH + STOP_BITS)
                    + TMO_W'(PAR_EN);
  assign presc_eff  = (Prescale == '0) ? TMO_W'(PRESC_FULL)
                                       : TMO_W'(Prescale);
  assign tmo_load   = (frame_bits + TMO_W'(1)) * presc_eff - TMO_W'(1);

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    apply   = 1'b0;
    err_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = FRAME;
          tmo_d   = tmo_load;
        end else if (cfg_pending && RX_IN) begin
          apply = 1'b1;
        end
      end
      FRAME: begin
        if (data_valid) begin
          state_d = IDLE;
        end else if (tmo_q == '0) begin
          state_d = IDLE;
          err_inc = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      rx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      rx_q    <= RX_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Prescale    <= scaler_width'(PRESCALE_RST);
      PAR_EN      <= PAR_EN_RST;
      PAR_TYP     <= PAR_TYP_RST;
      sh_prescale <= scaler_width'(PRESCALE_RST);
      sh_par_en   <= PAR_EN_RST;
      sh_par_typ  <= PAR_TYP_RST;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= cfg_wr & ~presc_legal;
      if (apply) begin
        Prescale <= sh_prescale;
        PAR_EN   <= sh_par_en;
        PAR_TYP  <= sh_par_typ;
      end
      if (cfg_wr && presc_legal) begin
        sh_prescale <= cfg_prescale;
        sh_par_en   <= cfg_par_en;
        sh_par_typ  <= cfg_par_typ;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;
  assign ovf_inc = data_valid & fifo_full & ~pop;

  uart_rx_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (data_valid),
    .pop   (pop),
    .wdata (P_DATA),
    .rdata (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt <= '0;
      ovf_cnt <= '0;
    end else if (clr_stats) begin
      err_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      if (err_inc && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (ovf_inc && ovf_cnt != 8'hFF) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
    end
  end

endmodule
